flexbus_master: RTL and testbench
=================================

FLEXBUS_MASTER -- requirements
Module: flexbus_master

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning extra data-phase cycles per transfer (legal 0..15).
REQ-002 SHALL have parameter ADDR_BASE, default 32'h60000000, meaning the value OR-ed onto req_addr to form the bus address.
REQ-003 SHALL have port CLK  input  1  single clock; the FlexBus clock supplied to the slave is this clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  transfer request.
REQ-006 SHALL have port req_rw  input  1  1 = read, 0 = write (FlexBus RW polarity).
REQ-007 SHALL have port req_addr  input  32  byte address offset.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle transfer-complete pulse.
REQ-011 SHALL have port rsp_rdata  output  32  read data, held until the next read completes.
REQ-012 SHALL have ports FB_ALE, FB_CSn and FB_RW, each an output of width 1 with FlexBus meaning.
REQ-013 SHALL have ports FB_AD_O (output, 32, drive value), FB_AD_OE (output, 1, drive enable) and FB_AD_I (input, 32, sampled bus).

Function
REQ-014 SHALL implement the FSM IDLE -> ADDR -> DATA -> TURN -> IDLE.
REQ-015 req_ready SHALL equal (state==IDLE), decoded from a register; handshake = req_valid & req_ready at a rising edge.
REQ-016 SHALL capture rw, address and wdata on handshake; request inputs are ignored outside IDLE.
REQ-017 ADDR (1 cycle) SHALL drive ALE=1, CSn=1, OE=1, AD_O=ADDR_BASE|addr, and RW=captured rw.
REQ-018 DATA (WAIT_STATES+1 cycles, counted by a 4-bit down-counter) SHALL drive ALE=0, CSn=0, and RW held.
REQ-019 In DATA on a write, SHALL drive OE=1 and AD_O=wdata; on a read, SHALL drive OE=0.
REQ-020 On a read, SHALL register FB_AD_I into rsp_rdata at the rising edge that ends the last DATA cycle.
REQ-021 TURN (1 cycle) SHALL drive CSn=1, ALE=0, OE=0, RW=1, and pulse rsp_valid=1 for both reads and writes.
REQ-022 All FB_* outputs and rsp_valid SHALL be registers; no combinational path from request inputs to bus pins.
REQ-023 SHALL give back-to-back throughput of one transfer per WAIT_STATES+4 cycles, with req_valid held high.
REQ-024 In IDLE, SHALL drive CSn=1, ALE=0, RW=1, OE=0, and AD_O=0.
REQ-025 A write SHALL leave rsp_rdata unchanged.

Reset
REQ-026 On RST assertion, SHALL immediately (asynchronously) enter IDLE and apply the REQ-024 levels, rsp_valid=0, rsp_rdata=0, and counter=0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no rsp_valid; CSn deasserts without waiting for a clock.
REQ-028 While RST is high, req_ready SHALL read 1, but no handshake SHALL be taken; the first accept is at the first edge after release.

Structure
REQ-029 SHALL place the FSM state encoding (2 bits), the wait-counter width constant (4), and the IDLE bus-level constants in the shared peripheral package.
REQ-030 SHALL have no sub-module; the 32-bit tristate (FB_AD = OE ? AD_O : Z) SHALL reside in the top level.

Verification
REQ-031 Write 0x000000A5 to offset 0x10, WAIT_STATES=1 -> ALE 1 cycle with AD=0x60000010, CSn low 2 cycles with AD=0xA5 and RW=0, rsp_valid in cycle 5 after accept.
REQ-032 Read offset 0x04 with the slave driving 0x12345678 -> OE=0 during DATA, rsp_rdata=0x12345678 with rsp_valid, RW=1 throughout.
REQ-033 Back-to-back write then read with req_valid held high -> second ALE exactly WAIT_STATES+4 cycles after the first; req_ready low throughout each transfer.
REQ-034 WAIT_STATES=0 and 15 -> CSn low for exactly 1 and 16 cycles respectively.
REQ-035 RST pulsed in the second DATA cycle of a read -> CSn=1 and OE=0 within the same cycle, no rsp_valid, rsp_rdata=0; the next request is served normally.
REQ-036 A write after a read of 0xDEADBEEF -> rsp_rdata stays 0xDEADBEEF.

Source files
------------

// File: rtl/flexbus_master_pkg.sv
// Shared FlexBus master types: FSM encoding, wait-counter width and idle pin levels.
package flexbus_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_TURN = 2'd3
  } fb_state_e;

  localparam int CNT_W = 4;

  localparam logic        IDLE_ALE = 1'b0;
  localparam logic        IDLE_CSN = 1'b1;
  localparam logic        IDLE_RW  = 1'b1;
  localparam logic        IDLE_OE  = 1'b0;
  localparam logic [31:0] IDLE_AD  = 32'h0;

  // Request fields that must survive past the address phase.
  typedef struct packed {
    logic        rw;
    logic [31:0] wdata;
  } fb_req_t;

  function automatic logic [31:0] bus_addr(input logic [31:0] base, input logic [31:0] off);
    return base | off;
  endfunction

endpackage

// File: rtl/flexbus_master_if.sv
// Request/response handshake plus FlexBus pin group for the FlexBus master.
interface flexbus_master_if;
  logic        req_valid;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        FB_ALE;
  logic        FB_CSn;
  logic        FB_RW;
  logic [31:0] FB_AD_O;
  logic        FB_AD_OE;
  logic [31:0] FB_AD_I;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, FB_AD_I,
    output req_ready, rsp_valid, rsp_rdata,
    output FB_ALE, FB_CSn, FB_RW, FB_AD_O, FB_AD_OE
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, FB_AD_I,
    input  req_ready, rsp_valid, rsp_rdata,
    input  FB_ALE, FB_CSn, FB_RW, FB_AD_O, FB_AD_OE
  );
endinterface

// File: rtl/flexbus_master.sv
// FlexBus master: one transfer per request, IDLE -> ADDR -> DATA(WAIT_STATES+1) -> TURN.
module flexbus_master
  import flexbus_master_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h6000_0000
) (
  input  logic             CLK,
  input  logic             RST,
  flexbus_master_if.master bus,
  inout  wire  [31:0]      FB_AD
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  fb_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  fb_req_t          r_req;
  logic             r_ale, r_csn, r_rw, r_oe, r_rsp_valid;
  logic [31:0]      r_ad, r_rdata;

  // Every pin level is set on the edge that enters the phase, so pins are pure flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_ale       <= IDLE_ALE;
      r_csn       <= IDLE_CSN;
      r_rw        <= IDLE_RW;
      r_oe        <= IDLE_OE;
      r_ad        <= IDLE_AD;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_state     <= S_ADDR;
            r_req.rw    <= bus.req_rw;
            r_req.wdata <= bus.req_wdata;
            r_ale       <= 1'b1;
            r_csn       <= 1'b1;
            r_oe        <= 1'b1;
            r_rw        <= bus.req_rw;
            r_ad        <= bus_addr(ADDR_BASE, bus.req_addr);
          end
        end
        S_ADDR: begin
          r_state <= S_DATA;
          r_cnt   <= WS_LOAD;
          r_ale   <= 1'b0;
          r_csn   <= 1'b0;
          r_oe    <= ~r_req.rw;
          r_ad    <= r_req.rw ? IDLE_AD : r_req.wdata;
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_state     <= S_TURN;
            r_ale       <= IDLE_ALE;
            r_csn       <= IDLE_CSN;
            r_rw        <= IDLE_RW;
            r_oe        <= IDLE_OE;
            r_ad        <= IDLE_AD;
            r_rsp_valid <= 1'b1;
            if (r_req.rw) r_rdata <= bus.FB_AD_I;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.FB_ALE    = r_ale;
  assign bus.FB_CSn    = r_csn;
  assign bus.FB_RW     = r_rw;
  assign bus.FB_AD_O   = r_ad;
  assign bus.FB_AD_OE  = r_oe;

  assign FB_AD = r_oe ? r_ad : {32{1'bz}};

endmodule

// File: tb/tb_flexbus_master.sv
// Bench for flexbus_master: cycle-phase model on the WAIT_STATES=1 instance plus directed literal checks.
module tb_flexbus_master;

  localparam int          WS   = 1;
  localparam logic [31:0] BASE = 32'h6000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  flexbus_master_if b1 ();
  flexbus_master_if b0 ();
  flexbus_master_if b15 ();
  wire [31:0] ad1, ad0, ad15;

  flexbus_master #(.WAIT_STATES(WS), .ADDR_BASE(BASE)) dut1  (.CLK(CLK), .RST(RST), .bus(b1.master),  .FB_AD(ad1));
  flexbus_master #(.WAIT_STATES(0),  .ADDR_BASE(BASE)) dut0  (.CLK(CLK), .RST(RST), .bus(b0.master),  .FB_AD(ad0));
  flexbus_master #(.WAIT_STATES(15), .ADDR_BASE(BASE)) dut15 (.CLK(CLK), .RST(RST), .bus(b15.master), .FB_AD(ad15));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the accepting edge (0 = no transfer in flight).
  // k=1 address phase, k=2..WS+2 data phase, k=WS+3 turnaround.
  int          m_k     = 0;
  logic        m_rw    = 1'b1;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_k     = 0;
      m_rdata = '0;
    end else if (m_k == 0) begin
      if (b1.req_valid) begin
        m_k     = 1;
        m_rw    = b1.req_rw;
        m_addr  = b1.req_addr;
        m_wdata = b1.req_wdata;
      end
    end else begin
      if (m_k == WS + 2 && m_rw) m_rdata = b1.FB_AD_I;
      m_k = (m_k == WS + 3) ? 0 : m_k + 1;
    end
  end

  always @(negedge CLK) begin
    chk("req_ready", b1.req_ready, m_k == 0);
    chk("rsp_valid", b1.rsp_valid, m_k == WS + 3);
    chk("rsp_rdata", b1.rsp_rdata, m_rdata);
    if (m_k == 0) begin
      chk("idle_ale", b1.FB_ALE, 0);
      chk("idle_csn", b1.FB_CSn, 1);
      chk("idle_rw",  b1.FB_RW, 1);
      chk("idle_oe",  b1.FB_AD_OE, 0);
      chk("idle_ad",  b1.FB_AD_O, 0);
    end else if (m_k == 1) begin
      chk("addr_ale", b1.FB_ALE, 1);
      chk("addr_csn", b1.FB_CSn, 1);
      chk("addr_oe",  b1.FB_AD_OE, 1);
      chk("addr_rw",  b1.FB_RW, m_rw);
      chk("addr_ad",  b1.FB_AD_O, BASE | m_addr);
    end else if (m_k <= WS + 2) begin
      chk("data_ale", b1.FB_ALE, 0);
      chk("data_csn", b1.FB_CSn, 0);
      chk("data_rw",  b1.FB_RW, m_rw);
      chk("data_oe",  b1.FB_AD_OE, !m_rw);
      if (!m_rw) chk("data_ad", b1.FB_AD_O, m_wdata);
    end else begin
      chk("turn_ale", b1.FB_ALE, 0);
      chk("turn_csn", b1.FB_CSn, 1);
      chk("turn_rw",  b1.FB_RW, 1);
      chk("turn_oe",  b1.FB_AD_OE, 0);
    end
    if (b1.FB_AD_OE) chk("fb_ad_pin", ad1, b1.FB_AD_O);
  end

  int   cyc = 0;
  logic prev_ale = 1'b0;
  int   ale_q[$];
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (b1.FB_ALE && !prev_ale) ale_q.push_back(cyc);
    prev_ale = b1.FB_ALE;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cnt, nv;
    b1.req_valid  = 0; b1.req_rw  = 0; b1.req_addr  = 0; b1.req_wdata  = 0; b1.FB_AD_I  = 0;
    b0.req_valid  = 0; b0.req_rw  = 0; b0.req_addr  = 0; b0.req_wdata  = 0; b0.FB_AD_I  = 0;
    b15.req_valid = 0; b15.req_rw = 0; b15.req_addr = 0; b15.req_wdata = 0; b15.FB_AD_I = 0;

    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_csn",   b1.FB_CSn, 1);
    chk("rst_ale",   b1.FB_ALE, 0);
    chk("rst_rw",    b1.FB_RW, 1);
    chk("rst_oe",    b1.FB_AD_OE, 0);
    chk("rst_ad",    b1.FB_AD_O, 0);
    chk("rst_ready", b1.req_ready, 1);
    chk("rst_rdata", b1.rsp_rdata, 0);
    RST = 1'b0;
    step();

    // Write 0xA5 to 0x10: presenting cycle is cycle 1, TURN is cycle 5.
    b1.req_valid = 1; b1.req_rw = 0; b1.req_addr = 32'h10; b1.req_wdata = 32'hA5;
    step(); b1.req_valid = 0;
    chk("wr_c2_ale", b1.FB_ALE, 1);
    chk("wr_c2_ad",  b1.FB_AD_O, 32'h6000_0010);
    step();
    chk("wr_c3_csn", b1.FB_CSn, 0);
    chk("wr_c3_ad",  b1.FB_AD_O, 32'hA5);
    chk("wr_c3_rw",  b1.FB_RW, 0);
    step();
    chk("wr_c4_csn", b1.FB_CSn, 0);
    chk("wr_c4_ad",  b1.FB_AD_O, 32'hA5);
    step();
    chk("wr_c5_rsp", b1.rsp_valid, 1);
    chk("wr_c5_csn", b1.FB_CSn, 1);
    step();
    chk("wr_c6_rsp", b1.rsp_valid, 0);

    // Read 0x04 with slave driving 0x12345678.
    b1.FB_AD_I = 32'h1234_5678;
    b1.req_valid = 1; b1.req_rw = 1; b1.req_addr = 32'h04;
    step(); b1.req_valid = 0;
    chk("rd_addr_rw", b1.FB_RW, 1);
    chk("rd_addr_ad", b1.FB_AD_O, 32'h6000_0004);
    step();
    chk("rd_d1_oe", b1.FB_AD_OE, 0);
    chk("rd_d1_rw", b1.FB_RW, 1);
    step();
    chk("rd_d2_oe", b1.FB_AD_OE, 0);
    step();
    chk("rd_rsp",   b1.rsp_valid, 1);
    chk("rd_rdata", b1.rsp_rdata, 32'h1234_5678);
    step();

    // Back-to-back write then read with req_valid held.
    ale_q.delete();
    b1.req_valid = 1; b1.req_rw = 0; b1.req_addr = 32'h30; b1.req_wdata = 32'h11;
    step();
    b1.req_rw = 1; b1.req_addr = 32'h34;
    repeat (5) @(posedge CLK);
    #1 b1.req_valid = 0;
    repeat (6) step();
    chk("b2b_ale_count", ale_q.size(), 2);
    if (ale_q.size() == 2) chk("b2b_ale_gap", ale_q[1] - ale_q[0], WS + 4);

    // Reset in the second data cycle of a read.
    b1.FB_AD_I = 32'hCAFE_F00D;
    b1.req_valid = 1; b1.req_rw = 1; b1.req_addr = 32'h08;
    step(); b1.req_valid = 0;
    step();
    @(posedge CLK); #2;
    chk("rstmid_pre_csn", b1.FB_CSn, 0);
    RST = 1'b1;
    #1;
    chk("rstmid_csn",   b1.FB_CSn, 1);
    chk("rstmid_oe",    b1.FB_AD_OE, 0);
    chk("rstmid_rsp",   b1.rsp_valid, 0);
    chk("rstmid_rdata", b1.rsp_rdata, 0);
    b1.req_valid = 1; b1.req_rw = 1; b1.req_addr = 32'h0C;
    step();
    chk("rsthold_ale",   b1.FB_ALE, 0);
    chk("rsthold_ready", b1.req_ready, 1);
    RST = 1'b0;
    b1.FB_AD_I = 32'hDEAD_BEEF;
    step(); b1.req_valid = 0;
    chk("post_rst_ale", b1.FB_ALE, 1);
    chk("post_rst_ad",  b1.FB_AD_O, 32'h6000_000C);
    repeat (3) step();
    chk("post_rst_rsp",   b1.rsp_valid, 1);
    chk("post_rst_rdata", b1.rsp_rdata, 32'hDEAD_BEEF);
    step();

    // A write must not disturb the held read data.
    b1.FB_AD_I = 32'h0;
    b1.req_valid = 1; b1.req_rw = 0; b1.req_addr = 32'h40; b1.req_wdata = 32'h5555_AAAA;
    step(); b1.req_valid = 0;
    repeat (3) step();
    chk("wr_keep_rsp",   b1.rsp_valid, 1);
    chk("wr_keep_rdata", b1.rsp_rdata, 32'hDEAD_BEEF);
    step();

    // WAIT_STATES = 0: chip select low exactly one cycle.
    b0.req_valid = 1; b0.req_rw = 0; b0.req_addr = 32'h50; b0.req_wdata = 32'h1;
    step(); b0.req_valid = 0;
    cnt = 0; nv = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!b0.FB_CSn) cnt++;
      if (b0.rsp_valid) nv++;
    end
    chk("ws0_csn_low", cnt, 1);
    chk("ws0_rsp_cnt", nv, 1);

    // WAIT_STATES = 15: chip select low exactly sixteen cycles.
    b15.FB_AD_I = 32'h0F0F_0F0F;
    b15.req_valid = 1; b15.req_rw = 1; b15.req_addr = 32'h60;
    step(); b15.req_valid = 0;
    cnt = 0; nv = 0;
    repeat (30) begin
      @(negedge CLK);
      if (!b15.FB_CSn) cnt++;
      if (b15.rsp_valid) nv++;
    end
    chk("ws15_csn_low", cnt, 16);
    chk("ws15_rsp_cnt", nv, 1);
    chk("ws15_rdata",   b15.rsp_rdata, 32'h0F0F_0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
